// File: rtl/div_sequencer.sv
// Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU group.
// One restoring quotient bit per cycle; divide-by-zero and signed overflow can exit early.
module div_sequencer #(
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [4:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] res_o
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned CNTW = 6;
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(XLEN);
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            is_rem_q, is_rem_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            bzero_q, bzero_d;
   logic            ovf_q, ovf_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] div_q, div_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] res_q, res_d;

   logic            valid_op_c;
   logic            accept_c;
   logic            signed_c;
   logic [XLEN-1:0] a_mag_c;
   logic [XLEN-1:0] b_mag_c;
   logic [XLEN:0]   trial_c;
   logic [XLEN:0]   diff_c;
   logic            fits_c;
   logic [XLEN-1:0] quo_fin_c;
   logic [XLEN-1:0] rem_fin_c;
   logic [XLEN-1:0] result_c;
   logic            early_c;

   // Request decode and handshake
   assign valid_op_c = (op_i[4:2] == 3'b101);
   assign accept_c   = start_i && !flush_i && valid_op_c && (state_q != S_CALC);
   assign signed_c   = !op_i[0];
   assign a_mag_c    = (signed_c && a_i[XLEN-1]) ? (~a_i + XLEN'(1)) : a_i;
   assign b_mag_c    = (signed_c && b_i[XLEN-1]) ? (~b_i + XLEN'(1)) : b_i;

   assign busy_o = accept_c || (state_q == S_CALC);
   assign done_o = (state_q == S_DONE) && !flush_i;
   assign res_o  = res_q;

   // One restoring step: shift in the next dividend bit and try the subtract
   assign trial_c = {rem_q, quo_q[XLEN-1]};
   assign diff_c  = trial_c - {1'b0, div_q};
   assign fits_c  = !diff_c[XLEN];

   assign quo_fin_c = neg_quo_q ? (~quo_q + XLEN'(1)) : quo_q;
   assign rem_fin_c = neg_rem_q ? (~rem_q + XLEN'(1)) : rem_q;
   assign early_c   = EARLY_OUT && (bzero_q || ovf_q);

   always_comb begin
      result_c = is_rem_q ? rem_fin_c : quo_fin_c;
      if (bzero_q) begin
         result_c = is_rem_q ? a_q : '1;
      end else if (ovf_q) begin
         result_c = is_rem_q ? '0 : INT_MIN;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      bzero_d   = bzero_q;
      ovf_d     = ovf_q;
      a_d       = a_q;
      div_d     = div_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      res_d     = res_q;

      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept_c) begin
                  state_d   = S_CALC;
                  cnt_d     = '0;
                  is_rem_d  = op_i[1];
                  neg_quo_d = signed_c && (a_i[XLEN-1] ^ b_i[XLEN-1]);
                  neg_rem_d = signed_c && a_i[XLEN-1];
                  bzero_d   = (b_i == '0);
                  ovf_d     = signed_c && (a_i == INT_MIN) && (b_i == '1);
                  a_d       = a_i;
                  div_d     = b_mag_c;
                  rem_d     = '0;
                  quo_d     = a_mag_c;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CALC: begin
               if (early_c || (cnt_q == LAST_CNT)) begin
                  state_d = S_DONE;
                  res_d   = result_c;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
                  rem_d = fits_c ? diff_c[XLEN-1:0] : trial_c[XLEN-1:0];
                  quo_d = {quo_q[XLEN-2:0], fits_c};
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         ovf_q     <= 1'b0;
         a_q       <= '0;
         div_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         bzero_q   <= bzero_d;
         ovf_q     <= ovf_d;
         a_q       <= a_d;
         div_q     <= div_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         res_q     <= res_d;
      end
   end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter EARLY_OUT, default 1, meaning divide-by-zero and signed-overflow cases bypass iteration and complete in 1 cycle (0 = always iterate 32 cycles, same results).
REQ-002 SHALL have port clk_i  input  1  rising-edge clock.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request valid from execute stage.
REQ-005 SHALL have port op_i  input  5  operation: 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
REQ-006 SHALL have port a_i  input  32  dividend.
REQ-007 SHALL have port b_i  input  32  divisor.
REQ-008 SHALL have port flush_i  input  1  pipeline flush, aborts any operation.
REQ-009 SHALL have port busy_o  output  1  pipeline stall request.
REQ-010 SHALL have port done_o  output  1  one-cycle result-valid strobe.
REQ-011 SHALL have port res_o  output  32  registered result.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE; one clock domain only.
REQ-013 SHALL accept a request in IDLE or DONE when start_i=1, flush_i=0 and op_i is one of the four divide codes; all other op_i values are ignored with no state change.
REQ-014 SHALL capture op_i, a_i, b_i on the accepting edge; later changes to inputs do not affect the operation.
REQ-015 SHALL, for a normal request, go to CALC, perform 32 restoring shift-subtract iterations (one quotient bit per cycle, MSB first) on the unsigned magnitudes, then enter DONE.
REQ-016 SHALL give latency: accept at edge 0, DONE entered at edge 33, done_o=1 for exactly the cycle after edge 33.
REQ-017 SHALL, in DONE, drive done_o=1 and res_o valid, then go to IDLE unless a new request is accepted on that edge (back-to-back allowed, then CALC).
REQ-018 SHALL drive busy_o combinationally: 1 when an acceptable request is presented in IDLE/DONE, or state=CALC; otherwise 0 (busy_o=0 in the DONE cycle without a new request).
REQ-019 SHALL use magnitudes for DIV/REM: operand negated when bit 31 set; quotient negated when signs of a and b differ; remainder takes the sign of a.
REQ-020 SHALL return for b=0: quotient 0xFFFFFFFF (DIV and DIVU), remainder = a (REM and REMU).
REQ-021 SHALL return for DIV/REM with a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-022 SHALL, when EARLY_OUT=1, route REQ-020/021 cases from acceptance directly to DONE (done_o in the cycle after edge 1); when EARLY_OUT=0 they take the full 33 cycles with identical results.
REQ-023 SHALL select quotient for DIV/DIVU and remainder for REM/REMU; result computed from 32-bit arithmetic, wrap-around not possible beyond REQ-021.
REQ-024 SHALL treat flush_i=1 in any state as synchronous abort: next state IDLE, no done_o, res_o unchanged; flush_i has priority over start_i and over DONE completion (done_o forced 0 that cycle).
REQ-025 SHALL hold res_o at its last value except on the edge entering DONE.

Reset
REQ-026 SHALL, while rst_ni=0, immediately force state IDLE, iteration counter 0, res_o=0, done_o=0, internal registers 0; busy_o follows REQ-018 from IDLE.
REQ-027 SHALL, on reset assertion during CALC or DONE, discard the operation without producing done_o after release.
REQ-028 SHALL resume accepting requests on the first rising edge after rst_ni returns to 1.

Verification
REQ-029 SHALL verify DIVU a=100 b=7 -> busy_o=1 for 33 cycles, done_o in cycle 34, res_o=14; REMU same operands -> res_o=2.
REQ-030 SHALL verify DIV a=0xFFFFFFF9 (-7) b=2 -> res_o=0xFFFFFFFD; REM same -> 0xFFFFFFFF; REM a=7 b=0xFFFFFFFE -> 1.
REQ-031 SHALL verify DIVU a=5 b=0 -> res_o=0xFFFFFFFF with done_o in cycle 2 (EARLY_OUT=1) and cycle 34 (EARLY_OUT=0); REMU a=5 b=0 -> 5.
REQ-032 SHALL verify DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-033 SHALL verify flush_i pulse at cycle 10 of CALC -> busy_o=0 next cycle, no done_o, res_o keeps previous value; a request issued alongside flush is ignored.
REQ-034 SHALL verify back-to-back: new DIVU 9/3 presented in DONE cycle of prior op -> prior done_o seen, second res_o=3 exactly 33 cycles later; rst_ni low mid-CALC -> res_o=0, no done_o.
